ifetch_branch_ctrl: RTL
=======================

// Module: ifetch_branch_ctrl
// PURPOSE
//  Fetch/control-flow stage consuming the program counter output and driving its branch/pcIn inputs.
//  Reads instruction memory at pc, registers it for the decoder, resolves JMP/JMPC/CAL/RET in-stage.
//  Maintains a return-address stack and holds the PC for stalls by reloading the current address.
// PARAMETERS
//  ADDR_W     8      program address width (equals PC width)
//  INSTR_W    16     instruction width; opcode = instr[INSTR_W-1 -: 4], target = instr[ADDR_W-1:0]
//  RAS_DEPTH  4      return-address stack entries (power of 2, >=2)
//  TRAP_ADDR  8'hF0  redirect address on stack error (IFETCH_TRAP_EN only)
// PORTS
//  clk          in   1        clock
//  reset        in   1        asynchronous, active-high reset
//  pc           in   ADDR_W   current program counter value
//  mem_data     in   INSTR_W  combinational instruction memory data at address pc
//  stall_in     in   1        downstream stall: hold instr_out and PC
//  cond_in      in   1        condition flag for JMPC (taken when 1)
//  cond_valid   in   1        cond_in is up to date; 0 = result pending
//  branch       out  1        load pc with branch_addr at next edge (combinational)
//  branch_addr  out  ADDR_W   address to load (combinational)
//  instr_out    out  INSTR_W  registered instruction to decoder
//  instr_valid  out  1        instr_out is a real instruction
//  ras_level    out  log2(RAS_DEPTH)+1  stack occupancy
//  stack_err    out  1        sticky overflow/underflow flag
// BEHAVIOUR
//  Reset (async): instr_out=0, instr_valid=0, ras_level=0, stack_err=0, stack entries cleared; branch=0 while reset high.
//  Latency: instruction at pc=A appears on instr_out/instr_valid=1 one edge later.
//  Opcodes (4'hC..4'hF) in mem_data, resolved same cycle, priority order per cycle:
//   1 stall_in=1: branch=1, branch_addr=pc; instr_out/instr_valid hold; stack unchanged.
//   2 JMPC with cond_valid=0: branch=1, branch_addr=pc; instr_valid<=0 (bubble).
//   3 JMP 4'hC: branch=1, addr=target. JMPC 4'hD: taken iff cond_in=1, else sequential.
//   4 CAL 4'hE: push pc+1 (mod 2^ADDR_W), branch to target. Full stack: no push, stack_err<=1, still branch to target.
//   5 RET 4'hF: pop, branch to popped address. Empty stack: no pop, stack_err<=1, sequential (acts as NOP).
//   6 other: branch=0 (PC increments), instr_out<=mem_data, instr_valid<=1.
//  Control-flow opcodes are consumed: instr_valid<=0 in their cycle; no wrong-path fetch occurs.
//  pc+1 wraps 0xFF->0x00; CAL at last address pushes 0x00.
//  stack_err cleared only by reset. Reset mid-stall or mid-wait drops all state; fetch restarts at pc=0.
// CONFIGURATION
//  IFETCH_TRAP_EN defined: on stack overflow/underflow, branch=1 to TRAP_ADDR (overrides target/NOP),
//   instr_valid<=0, stack_err<=1, stack unchanged.
//  Not defined: behaviour as above (overflow jumps to target, underflow is NOP), flag only.
// STRUCTURE
//  Shared package/defines: opcode constants OP_JMP/OP_JMPC/OP_CAL/OP_RET, opcode/target field positions,
//   ADDR_W/INSTR_W defaults shared with pgm counter and decoder.
//  One sub-module: ras_stack (push/pop/top/level/full/empty, synchronous push/pop, async reset).
//  Top: opcode decode + branch mux (combinational), output register, error flag.
// TESTING
//  Reset, mem[0..2]=3 non-branch words -> instr_out = mem[0],mem[1],mem[2] on cycles 1..3, branch=0.
//  mem[3]=JMP 0x40 -> at pc=3 branch=1, addr=0x40; next cycle instr_valid=0; then instr_out=mem[0x40].
//  CAL 0x20 at 0x05, RET at 0x20 -> push 0x06, ras_level 1->0, RET gives branch_addr=0x06.
//  5 nested CALs, RAS_DEPTH=4 -> 5th sets stack_err=1, ras_level=4; with IFETCH_TRAP_EN branch_addr=0xF0.
//  RET with empty stack -> stack_err=1, branch=0 (no trap) / branch_addr=0xF0 (trap).
//  stall_in=1 for 3 cycles -> branch=1, branch_addr=pc each cycle, instr_out unchanged.
//  JMPC 0x30 with cond_valid=0 for 2 cycles then cond_valid=1,cond_in=0 -> hold 2 cycles, not taken.

Source files
------------

// File: rtl/ifetch_branch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_branch_ctrl_pkg
// Description : Shared constants for the fetch / branch-control stage:
//               control-flow opcode values, instruction field positions and
//               default address/instruction widths shared with the program
//               counter and decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_branch_ctrl_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 16;
    localparam int OPC_W       = 4;

    // Control-flow opcodes (top nibble of the instruction word)
    localparam logic [OPC_W-1:0] OP_JMP  = 4'hC;
    localparam logic [OPC_W-1:0] OP_JMPC = 4'hD;
    localparam logic [OPC_W-1:0] OP_CAL  = 4'hE;
    localparam logic [OPC_W-1:0] OP_RET  = 4'hF;

    // True for any opcode that the fetch stage resolves and consumes itself
    function automatic logic is_ctrl_op(input logic [OPC_W-1:0] op);
        return (op == OP_JMP) || (op == OP_JMPC) || (op == OP_CAL) || (op == OP_RET);
    endfunction

endpackage : ifetch_branch_ctrl_pkg
`default_nettype wire

// File: rtl/ifetch_branch_ctrl_ras.sv
`default_nettype none
// ============================================================================
// Module      : ras_stack
// Description : Return-address stack. Synchronous push/pop, asynchronous
//               active-high reset that clears level and all entries.
//               Push on a full stack and pop on an empty stack are ignored.
// Ports       : clk, reset, i_push, i_pop, i_push_data -> o_top, o_level,
//               o_full, o_empty
// Revision    : 1.0 - initial release
// ============================================================================
module ras_stack #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [ADDR_W-1:0]        i_push_data,
    output logic [ADDR_W-1:0]        o_top,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LVL_W = IDX_W + 1;

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [LVL_W-1:0]  r_level;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_top_idx;

    // DEPTH is a power of two, so the low level bits index the next free slot;
    // level-1 truncated gives the top entry (also correct when full).
    assign w_wr_idx  = r_level[IDX_W-1:0];
    assign w_top_idx = r_level[IDX_W-1:0] - 1'b1;

    assign o_top   = r_mem[w_top_idx];
    assign o_level = r_level;
    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_push_data;
            r_level         <= r_level + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_level         <= r_level - 1'b1;
        end
    end

endmodule : ras_stack
`default_nettype wire

// File: rtl/ifetch_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_branch_ctrl
// Description : Fetch / control-flow stage. Reads instruction memory at pc,
//               registers non-control instructions for the decoder, resolves
//               JMP/JMPC/CAL/RET in the same cycle by driving branch /
//               branch_addr into the program counter, keeps a return-address
//               stack and holds the PC on stalls by reloading pc.
//               Build option: define IFETCH_TRAP_EN to redirect to TRAP_ADDR
//               on stack overflow/underflow.
// Ports       : clk, reset (async, active-high), pc, mem_data, stall_in,
//               cond_in, cond_valid -> branch, branch_addr, instr_out,
//               instr_valid, ras_level, stack_err
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_branch_ctrl
    import ifetch_branch_ctrl_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                INSTR_W   = INSTR_W_DEF,
    parameter int                RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] TRAP_ADDR = ADDR_W'('hF0)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          pc,
    input  logic [INSTR_W-1:0]         mem_data,
    input  logic                       stall_in,
    input  logic                       cond_in,
    input  logic                       cond_valid,
    output logic                       branch,
    output logic [ADDR_W-1:0]          branch_addr,
    output logic [INSTR_W-1:0]         instr_out,
    output logic                       instr_valid,
    output logic [$clog2(RAS_DEPTH):0] ras_level,
    output logic                       stack_err
);

`ifdef IFETCH_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [OPC_W-1:0]   w_opcode;
    logic [ADDR_W-1:0]  w_target;
    logic [ADDR_W-1:0]  w_pc_inc;
    logic [ADDR_W-1:0]  w_ras_top;
    logic               w_ras_full;
    logic               w_ras_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_set_err;
    logic               w_load;
    logic               w_bubble;

    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;
    logic               r_err;

    assign w_opcode = mem_data[INSTR_W-1 -: OPC_W];
    assign w_target = mem_data[ADDR_W-1:0];
    assign w_pc_inc = pc + 1'b1;   // wraps naturally at the top of the address space

    ras_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pc_inc),
        .o_top       (w_ras_top),
        .o_level     (ras_level),
        .o_full      (w_ras_full),
        .o_empty     (w_ras_empty)
    );

    // Decode and branch mux. A hold (stall or pending JMPC condition) is a
    // branch back to pc, so the PC reloads its own value.
    always_comb begin
        branch      = 1'b0;
        branch_addr = w_pc_inc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_set_err   = 1'b0;
        w_load      = 1'b0;
        w_bubble    = 1'b0;
        if (!reset) begin
            if (stall_in) begin
                branch      = 1'b1;
                branch_addr = pc;
            end else if (is_ctrl_op(w_opcode)) begin
                w_bubble = 1'b1;
                case (w_opcode)
                    OP_JMP: begin
                        branch      = 1'b1;
                        branch_addr = w_target;
                    end
                    OP_JMPC: begin
                        if (!cond_valid) begin
                            branch      = 1'b1;
                            branch_addr = pc;
                        end else if (cond_in) begin
                            branch      = 1'b1;
                            branch_addr = w_target;
                        end
                    end
                    OP_CAL: begin
                        branch      = 1'b1;
                        branch_addr = w_target;
                        if (w_ras_full) begin
                            w_set_err = 1'b1;
                            if (TRAP_EN) begin
                                branch_addr = TRAP_ADDR;
                            end
                        end else begin
                            w_push = 1'b1;
                        end
                    end
                    default: begin // OP_RET
                        if (w_ras_empty) begin
                            w_set_err = 1'b1;
                            if (TRAP_EN) begin
                                branch      = 1'b1;
                                branch_addr = TRAP_ADDR;
                            end
                        end else begin
                            w_pop       = 1'b1;
                            branch      = 1'b1;
                            branch_addr = w_ras_top;
                        end
                    end
                endcase
            end else begin
                w_load = 1'b1;
            end
        end
    end

    // Output register: stalls hold everything; consumed control-flow opcodes
    // leave instr_out untouched and only drop instr_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_load) begin
                r_instr <= mem_data;
                r_valid <= 1'b1;
            end else if (w_bubble) begin
                r_valid <= 1'b0;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign instr_out   = r_instr;
    assign instr_valid = r_valid;
    assign stack_err   = r_err;

endmodule : ifetch_branch_ctrl
`default_nettype wire
